// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data memory arbiter between pipeline load/store lane and debug/loader port
// Optional round-robin tie-break enabled by defining DMEM_ARB_RR_EN; fixed pipeline priority otherwise.
module dmem_arbiter #(
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_p_req,
  input  logic                       in_p_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_p_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_p_wdata,
  output logic                       out_p_gnt,
  output logic                       out_p_rvalid,
  output logic [DMEM_WORD_WIDTH-1:0] out_p_rdata,
  output logic                       out_stall,
  input  logic                       in_d_req,
  input  logic                       in_d_we,
  input  logic                       in_d_lock,
  input  logic [DMEM_ADDR_WIDTH-1:0] in_d_addr,
  input  logic [DMEM_WORD_WIDTH-1:0] in_d_wdata,
  output logic                       out_d_gnt,
  output logic                       out_d_rvalid,
  output logic [DMEM_WORD_WIDTH-1:0] out_d_rdata,
  output logic                       out_mem_en,
  output logic                       out_mem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_addr,
  output logic [DMEM_WORD_WIDTH-1:0] out_mem_wdata,
  input  logic [DMEM_WORD_WIDTH-1:0] in_mem_rdata
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t state_q, state_d;
  logic   last_d_q;
  logic   pend_q;
  logic   owner_d_q;
  logic   d_tie_win;
  logic   p_gnt, d_gnt;

`ifdef DMEM_ARB_RR_EN
  assign d_tie_win = ~last_d_q;
`else
  // Pointer is kept up to date but never consulted under fixed priority.
  assign d_tie_win = last_d_q & 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    p_gnt   = 1'b0;
    d_gnt   = 1'b0;
    case (state_q)
      IDLE: begin
        d_gnt = in_d_req & (~in_p_req | d_tie_win);
        p_gnt = in_p_req & ~d_gnt;
        if (d_gnt && in_d_lock) state_d = LOCKED;
      end
      LOCKED: begin
        // The cycle in which the lock drops is still served as locked.
        d_gnt = in_d_req;
        if (!in_d_lock) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      pend_q    <= 1'b0;
      owner_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (p_gnt) last_d_q <= 1'b0;
      else if (d_gnt) last_d_q <= 1'b1;
      pend_q <= (p_gnt & ~in_p_we) | (d_gnt & ~in_d_we);
      if (p_gnt || d_gnt) owner_d_q <= d_gnt;
    end
  end

  always_comb begin
    out_mem_en    = 1'b0;
    out_mem_we    = 1'b0;
    out_mem_addr  = '0;
    out_mem_wdata = '0;
    if (d_gnt) begin
      out_mem_en    = 1'b1;
      out_mem_we    = in_d_we;
      out_mem_addr  = in_d_addr;
      out_mem_wdata = in_d_wdata;
    end else if (p_gnt) begin
      out_mem_en    = 1'b1;
      out_mem_we    = in_p_we;
      out_mem_addr  = in_p_addr;
      out_mem_wdata = in_p_wdata;
    end
  end

  assign out_p_gnt    = p_gnt;
  assign out_d_gnt    = d_gnt;
  assign out_stall    = in_p_req & ~p_gnt;
  assign out_p_rvalid = pend_q & ~owner_d_q;
  assign out_d_rvalid = pend_q & owner_d_q;
  assign out_p_rdata  = out_p_rvalid ? in_mem_rdata : '0;
  assign out_d_rdata  = out_d_rvalid ? in_mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        p_req = 0, p_we = 0;
  logic [11:0] p_addr = 0;
  logic [15:0] p_wdata = 0;
  logic        d_req = 0, d_we = 0, d_lock = 0;
  logic [11:0] d_addr = 0;
  logic [15:0] d_wdata = 0;
  logic        p_gnt, p_rvalid, stall, d_gnt, d_rvalid;
  logic [15:0] p_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 0;
  logic [15:0] mem [0:4095];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .in_p_req(p_req), .in_p_we(p_we), .in_p_addr(p_addr), .in_p_wdata(p_wdata),
    .out_p_gnt(p_gnt), .out_p_rvalid(p_rvalid), .out_p_rdata(p_rdata), .out_stall(stall),
    .in_d_req(d_req), .in_d_we(d_we), .in_d_lock(d_lock), .in_d_addr(d_addr), .in_d_wdata(d_wdata),
    .out_d_gnt(d_gnt), .out_d_rvalid(d_rvalid), .out_d_rdata(d_rdata),
    .out_mem_en(mem_en), .out_mem_we(mem_we), .out_mem_addr(mem_addr), .out_mem_wdata(mem_wdata),
    .in_mem_rdata(mem_rdata)
  );

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) next_cycle();
    reset = 1'b1;
  endtask

  logic exp_d [0:3];
  logic exp_pv [0:4];
  logic exp_dv [0:4];

  initial begin
    mem[12'h010] = 16'hBEEF;
    mem[12'h020] = 16'h1111;
    mem[12'h030] = 16'h2222;

    // reset state
    #1;
    @(negedge clock);
    check("rst_p_gnt", p_gnt, 0);
    check("rst_d_gnt", d_gnt, 0);
    check("rst_p_rvalid", p_rvalid, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    check("rst_p_rdata", p_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    check("rst_mem_en", mem_en, 0);
    next_cycle();
    reset = 1'b1;
    next_cycle();

    @(negedge clock);
    check("idle_mem_en", mem_en, 0);
    check("idle_mem_addr", mem_addr, 0);
    next_cycle();

    // pipeline read alone
    p_req = 1; p_we = 0; p_addr = 12'h010;
    @(negedge clock);
    check("pr_p_gnt", p_gnt, 1);
    check("pr_mem_en", mem_en, 1);
    check("pr_mem_addr", mem_addr, 12'h010);
    check("pr_mem_we", mem_we, 0);
    check("pr_stall", stall, 0);
    next_cycle();
    p_req = 0;
    @(negedge clock);
    check("pr_p_rvalid", p_rvalid, 1);
    check("pr_p_rdata", p_rdata, 16'hBEEF);
    check("pr_d_rvalid", d_rvalid, 0);
    check("pr_d_rdata", d_rdata, 0);
    next_cycle();

    // tie: both read for 4 cycles from reset
    do_reset();
`ifdef DMEM_ARB_RR_EN
    exp_d = '{0, 1, 0, 1};
    exp_pv = '{0, 1, 0, 1, 0};
    exp_dv = '{0, 0, 1, 0, 1};
`else
    exp_d = '{0, 0, 0, 0};
    exp_pv = '{0, 1, 1, 1, 1};
    exp_dv = '{0, 0, 0, 0, 0};
`endif
    p_req = 1; p_we = 0; p_addr = 12'h020;
    d_req = 1; d_we = 0; d_addr = 12'h030;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin p_req = 0; d_req = 0; end
      @(negedge clock);
      if (i < 4) begin
        check($sformatf("tie_d_gnt%0d", i), d_gnt, exp_d[i]);
        check($sformatf("tie_p_gnt%0d", i), p_gnt, !exp_d[i]);
        check($sformatf("tie_stall%0d", i), stall, exp_d[i]);
      end
      check($sformatf("tie_p_rvalid%0d", i), p_rvalid, exp_pv[i]);
      check($sformatf("tie_d_rvalid%0d", i), d_rvalid, exp_dv[i]);
      check($sformatf("tie_p_rdata%0d", i), p_rdata, exp_pv[i] ? 16'h1111 : 16'h0);
      check($sformatf("tie_d_rdata%0d", i), d_rdata, exp_dv[i] ? 16'h2222 : 16'h0);
      next_cycle();
    end

    // debug lock: enter via a lone debug grant, then hold off the pipeline
    d_req = 1; d_lock = 1; d_we = 0; d_addr = 12'h030;
    @(negedge clock);
    check("lk_enter_d_gnt", d_gnt, 1);
    next_cycle();
    p_req = 1; p_addr = 12'h020;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check($sformatf("lk_d_gnt%0d", i), d_gnt, 1);
      check($sformatf("lk_p_gnt%0d", i), p_gnt, 0);
      check($sformatf("lk_stall%0d", i), stall, 1);
      check($sformatf("lk_d_rvalid%0d", i), d_rvalid, 1);
      check($sformatf("lk_d_rdata%0d", i), d_rdata, 16'h2222);
      next_cycle();
    end
    d_lock = 0; d_req = 0;
    @(negedge clock);
    check("lk_drop_p_gnt", p_gnt, 0);
    check("lk_drop_stall", stall, 1);
    next_cycle();
    @(negedge clock);
    check("lk_after_p_gnt", p_gnt, 1);
    check("lk_after_stall", stall, 0);
    next_cycle();
    p_req = 0;

    // lock without request has no effect
    d_lock = 1; p_req = 1;
    @(negedge clock);
    check("nolock_p_gnt", p_gnt, 1);
    next_cycle();
    @(negedge clock);
    check("nolock_p_gnt2", p_gnt, 1);
    next_cycle();
    d_lock = 0; p_req = 0;
    next_cycle();

    // debug write
    d_req = 1; d_we = 1; d_addr = 12'h0FF; d_wdata = 16'h1234;
    @(negedge clock);
    check("dw_d_gnt", d_gnt, 1);
    check("dw_mem_en", mem_en, 1);
    check("dw_mem_we", mem_we, 1);
    check("dw_mem_wdata", mem_wdata, 16'h1234);
    check("dw_mem_addr", mem_addr, 12'h0FF);
    next_cycle();
    d_req = 0; d_we = 0;
    @(negedge clock);
    check("dw_d_rvalid", d_rvalid, 0);
    check("dw_mem_stored", mem[12'h0FF], 16'h1234);
    next_cycle();

    // reset right after a granted pipeline read
    p_req = 1; p_we = 0; p_addr = 12'h010;
    @(negedge clock);
    check("rr_p_gnt", p_gnt, 1);
    next_cycle();
    p_req = 0;
    reset = 0;
    @(negedge clock);
    check("rr_p_rvalid_in_reset", p_rvalid, 0);
    check("rr_p_rdata_in_reset", p_rdata, 0);
    next_cycle();
    reset = 1;
    @(negedge clock);
    check("rr_p_rvalid_after", p_rvalid, 0);
    next_cycle();
    p_req = 1; d_req = 1; d_addr = 12'h030;
    @(negedge clock);
    check("rr_tie_p_gnt", p_gnt, 1);
    check("rr_tie_d_gnt", d_gnt, 0);
    next_cycle();
    p_req = 0; d_req = 0;
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
